// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core constants for the fetch path and the PC register.
//                Holds the PC select codes, the fault codes, the address window
//                and the fetch FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    // PC select codes driven towards the PC register
    localparam logic [1:0] PCSEL_ALU  = 2'b00;
    localparam logic [1:0] PCSEL_INC  = 2'b01;
    localparam logic [1:0] PCSEL_HOLD = 2'b10;

    // Fault codes reported on the sticky halt
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_PC      = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Legal instruction address window, shared with the PC register
    localparam logic [31:0] START_ADDRESS       = 32'h0100_0000;
    localparam logic [31:0] UPPER_ADDRESS_LIMIT = 32'h0100_0FFC;

    // Fetch FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_watchdog
//  Description : Bounds the time the fetch FSM may spend waiting for read data.
//                The counter is zero outside WAIT (so it is clear on entry) and
//                counts WAIT cycles without rvalid. o_timeout fires in the WAIT
//                cycle that would be the TIMEOUT_CYCLES-th one without data;
//                rvalid in that same cycle suppresses it.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_watchdog
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_in_wait,
    input  logic i_rvalid,
    output logic o_timeout
);

    // At least 8 bits, wider only if the limit needs it
    localparam int              CNT_W  = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                         $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count idle WAIT cycles; any other state holds the counter at zero
    always_ff @(posedge clk) begin
        if (rst || !i_in_wait) begin
            r_count <= '0;
        end else if (!i_rvalid) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_timeout = i_in_wait && !i_rvalid && (r_count == C_LAST);

endmodule : fetch_watchdog
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Multi-cycle instruction fetch controller. Issues one fetch at
//                a time, buffers the returned word for decode, honours stall
//                and redirect, and latches a sticky halt on a PC fault.
//                Build option FETCH_TIMEOUT_EN adds a WAIT-state watchdog that
//                halts with a timeout fault after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic        stall,
    input  logic        pc_halt,
    output logic [1:0]  pc_sel,
    output logic [31:0] instr,
    output logic        if_valid,
    output logic        flush,
    output logic        halted,
    output logic [1:0]  fault
);

    fetch_state_t r_state;
    logic         r_drop;      // in-flight fetch carried a stale address
    logic [31:0]  r_instr;
    logic         r_if_valid;
    logic         r_halted;
    logic [1:0]   r_fault;
    logic         w_imem_req;
    logic [1:0]   w_pc_sel;
    logic         w_timeout;

`ifdef FETCH_TIMEOUT_EN
    logic w_in_wait;
    assign w_in_wait = (r_state == ST_WAIT);

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_in_wait (w_in_wait),
        .i_rvalid  (imem_rvalid),
        .o_timeout (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout            = 1'b0;
`endif

    // Fetch FSM with its registered outputs (instr, if_valid, halted, fault)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_drop     <= 1'b0;
            r_instr    <= '0;
            r_if_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= FAULT_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (pc_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_PC;
                    end else if (imem_gnt) begin
                        r_state <= ST_WAIT;
                        // Granted in the redirect cycle: the address was stale
                        if (redirect) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop || redirect) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_REQ;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_if_valid <= 1'b1;
                            r_state    <= ST_DELIVER;
                        end
                    end else if (w_timeout) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_TIMEOUT;
                    end else if (redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_DELIVER: begin
                    if (redirect || !stall) begin
                        r_if_valid <= 1'b0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory request and PC select decode from state and live inputs
    always_comb begin
        w_imem_req = 1'b0;
        w_pc_sel   = PCSEL_HOLD;
        case (r_state)
            ST_REQ: begin
                w_imem_req = !pc_halt;
                if (redirect) begin
                    w_pc_sel = PCSEL_ALU;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_pc_sel = PCSEL_ALU;
                end
            end
            ST_DELIVER: begin
                if (redirect) begin
                    w_pc_sel = PCSEL_ALU;
                end else if (!stall) begin
                    w_pc_sel = PCSEL_INC;
                end
            end
            default: begin
                w_imem_req = 1'b0;
                w_pc_sel   = PCSEL_HOLD;
            end
        endcase
    end

    assign imem_req = w_imem_req;
    assign pc_sel   = w_pc_sel;
    assign flush    = redirect && (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign instr    = r_instr;
    assign if_valid = r_if_valid;
    assign halted   = r_halted;
    assign fault    = r_fault;

endmodule : fetch_sequencer
`default_nettype wire
